// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the execute-cluster ALU arbiter: opcode encodings and requester IDs.
// Constants only; imported by the ALU, the arbiter top and the bench.
package alu_arbiter_pkg;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_ADD  = 2;
  localparam int OP_XOR  = 3;
  localparam int OP_SLL  = 4;
  localparam int OP_SRL  = 5;
  localparam int OP_SUB  = 6;
  localparam int OP_SLTU = 7;
  localparam int OP_SLT  = 8;
  localparam int OP_SRA  = 9;
  localparam int OP_LAST = 9;

  localparam logic REQ_INT = 1'b0;
  localparam logic REQ_AGU = 1'b1;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two issuing units, the arbiter and writeback.
// master = requester/consumer side, slave = the arbiter.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
);

  logic             req0_valid;
  logic             req0_ready;
  logic [OPW-1:0]   req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [OPW-1:0]   req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic             rsp_err;
  logic [CNTW-1:0]  ops_done;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, ops_done
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, ops_done
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Purely combinational ALU (0 cycles); no flow control. Shift amount is taken as-is from b,
// callers are responsible for masking it. Illegal opcodes produce 0.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic [OPW-1:0]   i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_res,
  output logic             o_zero
);

  logic w_lt_s;
  logic w_lt_u;

  assign w_lt_s = $signed(i_a) < $signed(i_b);
  assign w_lt_u = i_a < i_b;

  always_comb begin
    o_res = '0;
    case (i_op)
      OPW'(OP_AND):  o_res = i_a & i_b;
      OPW'(OP_OR):   o_res = i_a | i_b;
      OPW'(OP_ADD):  o_res = i_a + i_b;
      OPW'(OP_XOR):  o_res = i_a ^ i_b;
      OPW'(OP_SLL):  o_res = i_a << i_b;
      OPW'(OP_SRL):  o_res = i_a >> i_b;
      OPW'(OP_SUB):  o_res = i_a - i_b;
      OPW'(OP_SLTU): o_res = {{(WIDTH-1){1'b0}}, w_lt_u};
      OPW'(OP_SLT):  o_res = {{(WIDTH-1){1'b0}}, w_lt_s};
      OPW'(OP_SRA):  o_res = $unsigned($signed(i_a) >>> i_b);
      default:       o_res = '0;
    endcase
  end

  assign o_zero = (o_res == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between the integer pipe and the AGU; result registered, 1-cycle latency.
// Single-entry response buffer: accepts when empty or draining, so 1 op/cycle sustains; requests stall on a held result.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 4,
  parameter int CNTW  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef struct packed {
    logic             id;
    logic             err;
    logic             zero;
    logic [WIDTH-1:0] data;
  } rsp_t;

  logic            r_rsp_valid;
  rsp_t            r_rsp;
  logic            r_ptr;
  logic [CNTW-1:0] r_ops_done;

  logic             w_acc;
  logic             w_grant_vld;
  logic             w_grant_id;
  logic [OPW-1:0]   w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_b_alu;
  logic             w_shift;
  logic             w_illegal;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_zero;
  rsp_t             w_rsp;

  assign w_acc = !r_rsp_valid || bus.rsp_ready;

  // Pointer only breaks ties; a lone requester is always served.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = REQ_INT;
    if (w_acc) begin
      case ({bus.req1_valid, bus.req0_valid})
        2'b01: begin
          w_grant_vld = 1'b1;
          w_grant_id  = REQ_INT;
        end
        2'b10: begin
          w_grant_vld = 1'b1;
          w_grant_id  = REQ_AGU;
        end
        2'b11: begin
          w_grant_vld = 1'b1;
          w_grant_id  = r_ptr;
        end
        default: begin
          w_grant_vld = 1'b0;
          w_grant_id  = REQ_INT;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_grant_vld && (w_grant_id == REQ_INT);
  assign bus.req1_ready = w_grant_vld && (w_grant_id == REQ_AGU);

  assign w_op = (w_grant_id == REQ_AGU) ? bus.req1_op : bus.req0_op;
  assign w_a  = (w_grant_id == REQ_AGU) ? bus.req1_a  : bus.req0_a;
  assign w_b  = (w_grant_id == REQ_AGU) ? bus.req1_b  : bus.req0_b;

  assign w_shift = (w_op == OPW'(OP_SLL)) || (w_op == OPW'(OP_SRL)) ||
                   (w_op == OPW'(OP_SRA));
  assign w_illegal = (w_op > OPW'(OP_LAST));
  assign w_b_alu = w_shift ? {{(WIDTH-SHW){1'b0}}, w_b[SHW-1:0]} : w_b;

  alu_arbiter_alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .i_op   (w_op),
    .i_a    (w_a),
    .i_b    (w_b_alu),
    .o_res  (w_alu_res),
    .o_zero (w_alu_zero)
  );

  always_comb begin
    w_rsp.id   = w_grant_id;
    w_rsp.err  = w_illegal;
    w_rsp.zero = w_illegal ? 1'b1 : w_alu_zero;
    w_rsp.data = w_illegal ? '0 : w_alu_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
      r_ptr       <= REQ_INT;
      r_ops_done  <= '0;
    end else begin
      if (w_grant_vld) begin
        r_rsp_valid <= 1'b1;
        r_rsp       <= w_rsp;
        r_ptr       <= ~w_grant_id;
      end else if (bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      if (r_rsp_valid && bus.rsp_ready) begin
        r_ops_done <= r_ops_done + 1'b1;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp.id;
  assign bus.rsp_data  = r_rsp.data;
  assign bus.rsp_zero  = r_rsp.zero;
  assign bus.rsp_err   = r_rsp.err;
  assign bus.ops_done  = r_ops_done;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU between two requesters: req0 is the integer pipe, req1 is the address/branch-compare unit.
- Each requester has a valid/ready port. Grants alternate round-robin; the ALU result is registered into a single-entry response buffer with valid/ready backpressure.
- Sits between the issue stage and writeback. The block owns the only ALU instance in the execute cluster.

Parameters:
- WIDTH, 32, operand and result width.
- OPW, 4, opcode width.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  OPW  opcode.
- req0_a  in  WIDTH  operand a.
- req0_b  in  WIDTH  operand b.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as req0, for requester 1.
- rsp_valid  out  1  response buffer holds a result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_id  out  1  requester that issued the result (0/1).
- rsp_data  out  WIDTH  ALU result.
- rsp_zero  out  1  rsp_data == 0.
- rsp_err  out  1  opcode was illegal (10..15).
- ops_done  out  CNTW  count of responses consumed; wraps.

Behaviour:
- Reset (rst_n low, async): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_zero=0, rsp_err=0, ops_done=0, round-robin pointer=0 (req0 favoured). Reset mid-operation discards the buffered result; no response for it is ever produced.
- Opcodes: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 SLL, 5 SRL, 6 SUB, 7 SLTU, 8 SLT, 9 SRA.
- For shifts (4, 5, 9), the shift amount is b[4:0]; the controller masks b before the ALU.
- Illegal op (10..15): ALU output is ignored; rsp_data=0, rsp_zero=1, rsp_err=1.
- Accept enable: acc = !rsp_valid || rsp_ready. Accepting into a full buffer that drains in the same cycle is allowed, giving 1 op/cycle sustained.
- Grant (combinational, only when acc=1):
  - only one valid: grant it;
  - both valid: grant the requester named by the pointer;
  - neither valid: no grant.
- reqN_ready = acc && grant==N. At most one ready per cycle. Ready may depend on valid; valid must not depend on ready.
- Pointer update: on any grant to N, pointer becomes 1-N. With no grant the pointer holds. Under continuous dual requests grants therefore alternate strictly; neither requester waits more than one granted op.
- Latency: operation granted in cycle t appears with rsp_valid=1 in cycle t+1.
- Response buffer:
  - On grant, it loads data/zero/err/id.
  - On rsp_ready with no grant, it clears rsp_valid; data fields hold their last value.
  - While rsp_valid=1 and rsp_ready=0, all rsp_* outputs are stable and both ready outputs are 0.
- ops_done increments on each cycle where rsp_valid && rsp_ready. It wraps from 2^CNTW-1 to 0.
- Requesters are expected to hold op/a/b stable while valid and not ready. The block samples them only in the grant cycle.

Decomposition:
- Shared package/header:
  - ALU opcode constants (OP_AND=0 … OP_SRA=9) and OP_LAST=9 for the illegal-op check;
  - requester ID constants REQ_INT=0, REQ_AGU=1.
- One sub-module instance: the existing ALU block (ALU), driven from the grant mux. Its zero output is used for legal ops.
- The arbiter logic (pointer + grant) stays inline; a separate module is not warranted for two requesters.

Test Plan:
- Reset: assert rst_n=0 mid-run with rsp_valid=1 -> all outputs 0 immediately. After release, req1 alone with ADD 5+7 -> req1_ready=1, next cycle rsp_valid=1, rsp_id=1, rsp_data=12, rsp_zero=0.
- Round-robin: both valid every cycle, rsp_ready=1, req0=SUB 9-9, req1=SLTU 3<4 -> rsp_id sequence 0,1,0,1. Data alternates 0 (zero=1) / 1 (zero=0). One op per cycle.
- Backpressure:
  - rsp_ready=0 for 3 cycles after XOR 0xF0F0F0F0^0xFFFFFFFF -> rsp_data=0x0F0F0F0F held stable; req*_ready=0 throughout.
  - rsp_ready=1 -> accept resumes the same cycle; ops_done increments by 1.
- Signed/unsigned:
  - SLT a=0xFFFFFFFF b=1 -> 1; SLTU same operands -> 0.
  - SLL a=1 b=0x00000024 -> shift masked to 4 -> 0x10.
- Illegal op: req0_op=12 -> rsp_err=1, rsp_data=0, rsp_zero=1, rsp_id=0. The following legal op clears rsp_err.
- Counter wrap: CNTW=4, 17 consumed responses -> ops_done=1.
